// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives cpu_alu op/operand selects plus datapath enables.
package cpu_alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_opcode_t;
endpackage

module cpu_multicycle_ctrl
    import cpu_alu_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        z_flag,
    input  logic        mem_ready,
    output alu_opcode_t alu_op_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  imm_src,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        illegal_instr
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]  state, state_next;
    logic        rdy;
    alu_opcode_t dec_op;
    logic        alu_legal;
    logic        instr_legal;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // funct3 -> ALU op; funct7_5 only selects SUB for R-type
    always_comb begin
        dec_op    = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            3'b000:  dec_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  dec_op = ALU_SLT;
            3'b110:  dec_op = ALU_OR;
            3'b111:  dec_op = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_JAL: instr_legal = 1'b1;
            OP_R, OP_I:           instr_legal = alu_legal;
            OP_BR:                instr_legal = (funct3 == 3'b000);
            default:              instr_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_legal)             state_next = S_FETCH;
                else if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
                else if (opcode == OP_R)      state_next = S_EXECUTER;
                else if (opcode == OP_I)      state_next = S_EXECUTEI;
                else if (opcode == OP_BR)     state_next = S_BEQ;
                else                          state_next = S_JAL;
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (rdy) state_next = S_MEMWB;
            S_MEMWRITE: if (rdy) state_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Reset forces every output inactive, including a pending mem_write
    always_comb begin
        alu_op_sel    = ALU_ADD;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        imm_src       = 2'b00;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        illegal_instr = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = rdy;
                    pc_write   = rdy;
                end
                S_DECODE: begin
                    alu_src_a     = 2'b01;
                    alu_src_b     = 2'b01;
                    imm_src       = 2'b10;
                    illegal_instr = !instr_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_LW) ? 2'b00 : 2'b01;
                end
                S_MEMREAD:  adr_src = 1'b1;
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    alu_src_a  = 2'b10;
                    alu_op_sel = dec_op;
                end
                S_EXECUTEI: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    alu_op_sel = dec_op;
                end
                S_ALUWB:    reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a  = 2'b10;
                    alu_op_sel = ALU_SUB;
                    pc_write   = z_flag;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    imm_src   = 2'b11;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Scoreboard bench for cpu_multicycle_ctrl: one handshaking instance and one
// MEM_HANDSHAKE=0 instance, expected output vectors queued per cycle.
module tb_cpu_multicycle_ctrl;
    import cpu_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2, funct7_5, z_flag, mem_ready, mem_ready2;
    logic [6:0] opcode;
    logic [2:0] funct3;

    alu_opcode_t d1_op, d2_op;
    logic [1:0]  d1_sa, d1_sb, d1_rs, d1_is, d2_sa, d2_sb, d2_rs, d2_is;
    logic        d1_adr, d1_irw, d1_pcw, d1_rw, d1_mw, d1_ill;
    logic        d2_adr, d2_irw, d2_pcw, d2_rw, d2_mw, d2_ill;

    cpu_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) u_hs (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .z_flag(z_flag), .mem_ready(mem_ready), .alu_op_sel(d1_op), .alu_src_a(d1_sa),
        .alu_src_b(d1_sb), .result_src(d1_rs), .imm_src(d1_is), .adr_src(d1_adr),
        .ir_write(d1_irw), .pc_write(d1_pcw), .reg_write(d1_rw), .mem_write(d1_mw),
        .illegal_instr(d1_ill));

    cpu_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) u_nohs (
        .clk(clk), .rst(rst2), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .z_flag(z_flag), .mem_ready(mem_ready2), .alu_op_sel(d2_op), .alu_src_a(d2_sa),
        .alu_src_b(d2_sb), .result_src(d2_rs), .imm_src(d2_is), .adr_src(d2_adr),
        .ir_write(d2_irw), .pc_write(d2_pcw), .reg_write(d2_rw), .mem_write(d2_mw),
        .illegal_instr(d2_ill));

    // {op, src_a, src_b, result_src, imm_src, adr, ir_w, pc_w, reg_w, mem_w, ill}
    logic [16:0] obs1, obs2;
    assign obs1 = {d1_op, d1_sa, d1_sb, d1_rs, d1_is, d1_adr, d1_irw, d1_pcw, d1_rw, d1_mw, d1_ill};
    assign obs2 = {d2_op, d2_sa, d2_sb, d2_rs, d2_is, d2_adr, d2_irw, d2_pcw, d2_rw, d2_mw, d2_ill};

    typedef struct {
        string       tag;
        logic [16:0] e1;
        logic [16:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [16:0] mk(alu_opcode_t op, logic [1:0] sa, logic [1:0] sb_,
                                       logic [1:0] rs, logic [1:0] is, logic adr, logic irw,
                                       logic pcw, logic rw, logic mw, logic ill);
        return {op, sa, sb_, rs, is, adr, irw, pcw, rw, mw, ill};
    endfunction

    logic [16:0] IDLE, F_RDY, F_WAIT, DEC, DEC_ILL, WB, MA_LW, MA_SW, MRD, MWB, MWR, JALS;

    function automatic logic [16:0] exr(alu_opcode_t op);
        return mk(op, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] exi(alu_opcode_t op);
        return mk(op, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [16:0] beqs(logic z);
        return mk(ALU_SUB, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, z, 0, 0, 0);
    endfunction

    task automatic step(input string tag, input logic [16:0] e1, input logic [16:0] e2);
        exp_t e;
        e.tag = tag; e.e1 = e1; e.e2 = e2;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic s1(input string tag, input logic [16:0] e1);
        step(tag, e1, IDLE);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op; funct3 = f3; funct7_5 = f7;
    endtask

    // Monitor: outputs are valid every cycle, so compare once per negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (obs1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s hs: got %h want %h", e.tag, obs1, e.e1);
                end
                n_cmp++;
                if (obs2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s nohs: got %h want %h", e.tag, obs2, e.e2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        IDLE    = '0;
        F_RDY   = mk(ALU_ADD, 2'b00, 2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 0, 0);
        F_WAIT  = mk(ALU_ADD, 2'b00, 2'b10, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        DEC     = mk(ALU_ADD, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
        DEC_ILL = mk(ALU_ADD, 2'b01, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 1);
        WB      = mk(ALU_ADD, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
        MA_LW   = mk(ALU_ADD, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        MA_SW   = mk(ALU_ADD, 2'b10, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
        MRD     = mk(ALU_ADD, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
        MWB     = mk(ALU_ADD, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
        MWR     = mk(ALU_ADD, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0);
        JALS    = mk(ALU_ADD, 2'b01, 2'b10, 2'b00, 2'b11, 0, 0, 1, 0, 0, 0);

        rst = 1'b1; rst2 = 1'b1; z_flag = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        @(posedge clk); #1;
        s1("rst0", IDLE);
        s1("rst1", IDLE);
        rst = 1'b0;

        set_instr(7'b0110011, 3'b000, 1'b0);
        s1("add_f", F_RDY); s1("add_d", DEC); s1("add_ex", exr(ALU_ADD)); s1("add_wb", WB);
        set_instr(7'b0110011, 3'b000, 1'b1);
        s1("sub_f", F_RDY); s1("sub_d", DEC); s1("sub_ex", exr(ALU_SUB)); s1("sub_wb", WB);
        set_instr(7'b0010011, 3'b000, 1'b1);
        s1("addi_f", F_RDY); s1("addi_d", DEC); s1("addi_ex", exi(ALU_ADD)); s1("addi_wb", WB);
        set_instr(7'b0010011, 3'b110, 1'b0);
        s1("ori_f", F_RDY); s1("ori_d", DEC); s1("ori_ex", exi(ALU_OR)); s1("ori_wb", WB);
        set_instr(7'b0110011, 3'b010, 1'b0);
        s1("slt_f", F_RDY); s1("slt_d", DEC); s1("slt_ex", exr(ALU_SLT)); s1("slt_wb", WB);
        set_instr(7'b0010011, 3'b111, 1'b0);
        s1("andi_f", F_RDY); s1("andi_d", DEC); s1("andi_ex", exi(ALU_AND)); s1("andi_wb", WB);

        set_instr(7'b1100011, 3'b000, 1'b0);
        z_flag = 1'b1;
        s1("beqt_f", F_RDY); s1("beqt_d", DEC); s1("beqt_ex", beqs(1'b1));
        z_flag = 1'b0;
        s1("beqn_f", F_RDY); s1("beqn_d", DEC); s1("beqn_ex", beqs(1'b0));

        set_instr(7'b1101111, 3'b000, 1'b0);
        s1("jal_f", F_RDY); s1("jal_d", DEC); s1("jal_ex", JALS); s1("jal_wb", WB);

        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        s1("lw_fw1", F_WAIT); s1("lw_fw2", F_WAIT);
        mem_ready = 1'b1;
        s1("lw_f", F_RDY); s1("lw_d", DEC); s1("lw_ma", MA_LW);
        mem_ready = 1'b0;
        s1("lw_mw1", MRD); s1("lw_mw2", MRD); s1("lw_mw3", MRD);
        mem_ready = 1'b1;
        s1("lw_mr", MRD); s1("lw_wb", MWB);

        set_instr(7'b0000000, 3'b000, 1'b0);
        s1("ill0_f", F_RDY); s1("ill0_d", DEC_ILL);
        set_instr(7'b0110011, 3'b001, 1'b0);
        s1("illr_f", F_RDY); s1("illr_d", DEC_ILL);
        set_instr(7'b1100011, 3'b001, 1'b0);
        s1("illb_f", F_RDY); s1("illb_d", DEC_ILL);

        set_instr(7'b0100011, 3'b010, 1'b0);
        s1("sw_f", F_RDY); s1("sw_d", DEC); s1("sw_ma", MA_SW); s1("sw_mw", MWR);
        s1("sw2_f", F_RDY); s1("sw2_d", DEC); s1("sw2_ma", MA_SW);
        mem_ready = 1'b0;
        s1("sw2_mw1", MWR);
        rst = 1'b1;
        s1("sw2_rst", IDLE);
        s1("sw2_rsth", IDLE);
        mem_ready = 1'b1;
        s1("sw2_rsth2", IDLE);

        rst2 = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b1);
        step("nohs_f", IDLE, F_RDY);
        step("nohs_d", IDLE, DEC);
        step("nohs_ma", IDLE, MA_LW);
        step("nohs_mr", IDLE, MRD);
        step("nohs_wb", IDLE, MWB);
        step("nohs_f2", IDLE, F_RDY);

        @(negedge clk); #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback.
- It is the driving end of the cpu_alu interface: it produces op_sel and the operand-select controls, and consumes z_flag for branch resolution.
- It also drives register-file, instruction-register, PC and memory enables, with a mem_ready wait handshake.
- Supported subset: lw, sw, R-type add/sub/and/or/slt, I-type addi/slti/ori/andi, beq, jal.

Parameters:
- MEM_HANDSHAKE, 1, 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready. 0: mem_ready is ignored and treated as 1.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- z_flag  input  1  cpu_alu zero flag
- mem_ready  input  1  memory access complete this cycle
- alu_op_sel  output  alu_opcode_t  cpu_alu op_sel: ADD/SUB/AND/OR/SLT
- alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1 data
- alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4
- result_src  output  2  00 ALU-out register, 01 memory read data, 10 alu_out direct
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- adr_src  output  1  0 PC, 1 result
- ir_write  output  1  latch instruction and oldPC
- pc_write  output  1  load PC from result
- reg_write  output  1  register-file write enable
- mem_write  output  1  memory write request
- illegal_instr  output  1  one-cycle pulse on an unsupported encoding

Behaviour:
- State register holds one of: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- On a rising edge with rst=1, state becomes FETCH.
- While rst=1, all outputs are forced inactive: enables 0, selects 00, alu_op_sel ADD, illegal_instr 0.
- Outputs are combinational from state. Exceptions: pc_write in BEQ depends on z_flag; ir_write/pc_write in FETCH depend on mem_ready.
- Any output not listed for a state is 0, and alu_op_sel defaults to ADD.
- Let rdy = mem_ready when MEM_HANDSHAKE=1, otherwise rdy = 1.
- FETCH:
  - Outputs: adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10, ir_write=rdy, pc_write=rdy.
  - Next: DECODE when rdy, otherwise stay.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, imm_src=10, ADD (branch-target precompute).
  - Next by opcode:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER, if legal.
    - 0010011: EXECUTEI, if legal.
    - 1100011 with funct3=000: BEQ.
    - 1101111: JAL.
    - Anything else: FETCH, with illegal_instr=1 during DECODE.
- Legality and ALU op decode:
  - funct3=000: R-type gives SUB when funct7_5=1, ADD otherwise. I-type always gives ADD.
  - funct3=010: SLT. funct3=110: OR. funct3=111: AND.
  - Other funct3 values are illegal for R-type and I-type.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, ADD, imm_src = 00 for lw, 01 for sw.
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD:
  - Outputs: result_src=00, adr_src=1.
  - Next: MEMWB when rdy, otherwise stay.
- MEMWB:
  - Outputs: result_src=01, reg_write=1.
  - Next: FETCH.
- MEMWRITE:
  - Outputs: result_src=00, adr_src=1, mem_write=1, held every cycle until rdy.
  - Next: FETCH when rdy.
- EXECUTER:
  - Outputs: alu_src_a=10, alu_src_b=00, decoded op.
  - Next: ALUWB.
- EXECUTEI:
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=00, decoded op.
  - Next: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1.
  - Next: FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=z_flag.
  - Next: FETCH.
- JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, ADD, result_src=00, imm_src=11, pc_write=1.
  - Next: ALUWB (rd = oldPC+4).
- Latency with rdy constantly 1:
  - R/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
  - illegal: 2 cycles.
- Each memory wait adds one cycle per cycle with rdy=0; outputs stay stable during a wait.
- funct7_5 is ignored for all non-R-type opcodes.
- opcode/funct inputs are sampled only in DECODE, MEMADR, EXECUTER and EXECUTEI; they are stable there because the IR is not written.
- Reset asserted in any state, including mid-wait in MEMWRITE:
  - mem_write drops in the same cycle (combinational force).
  - The next state is FETCH.
  - No partial writeback occurs.

Test Plan:
- Reset then add (opcode 0110011, f3 000, f7_5 0), mem_ready=1:
  - States FETCH, DECODE, EXECUTER, ALUWB.
  - EXECUTER has op ADD, src_a=10, src_b=00; reg_write=1 only in cycle 4; next state FETCH.
- sub (f7_5=1) -> SUB in EXECUTER. Then addi with f7_5=1 (0010011, f3 000) -> ADD. Then ori (f3 110) -> OR with src_b=01, imm_src=00.
- beq (1100011, f3 000):
  - z_flag=1 -> pc_write=1 in cycle 3, op SUB.
  - z_flag=0 -> pc_write=0 throughout BEQ.
  - Both cases return to FETCH in cycle 4.
- lw with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - ir_write occurs only on the ready FETCH cycle.
  - reg_write with result_src=01 occurs on cycle 10.
  - Repeat with MEM_HANDSHAKE=0 and mem_ready=0 held -> completes in 5 cycles.
- Illegal opcode 0000000, and R-type f3=001 -> illegal_instr=1 for exactly one cycle in DECODE; no reg_write, pc_write or mem_write; FETCH next.
- sw with mem_ready=0, rst=1 asserted on the 2nd MEMWRITE cycle:
  - mem_write=0 in that cycle.
  - State is FETCH after the edge.
  - All outputs are inactive until rst=0.
